fcmp_pipe: RTL and testbench
============================

Name: fcmp_pipe

Overview:
- Parametrised, pipelined floating-point comparator for the FloPoCo operand format {exc[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
- Exception encoding: 00 zero, 01 normal, 10 inf, 11 NaN.
- Evaluates one of eight predicates per transaction, selected by an opcode carried with the operands.
- Valid/ready streaming interface with back-pressure.
- Drop-in comparison unit for HLS-generated datapaths that need LT/LE/EQ/etc. with a uniform latency.

Parameters:
- WE, 5, exponent width (2..11).
- WF, 5, fraction width (1..52).
- STAGES, 2, pipeline depth, i.e. latency in cycles (1..3).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  WE+WF+3  operand X.
- in_y  in  WE+WF+3  operand Y.
- in_op  in  3  predicate: 0 LT, 1 LE, 2 EQ, 3 GT, 4 GE, 5 NE, 6 ORD, 7 UNO.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  1  predicate result.
- out_unord  out  1  X or Y is NaN.
- out_invalid  out  1  signalling-compare invalid (macro only; otherwise tied 0).
- flag_clr  in  1  clears the sticky invalid flag (macro only; otherwise ignored).
- flag_sticky  out  1  sticky OR of out_invalid over accepted results (macro only; otherwise tied 0).

Behaviour:
- Reset: every stage valid bit = 0, out_valid = 0, out_res = 0, out_unord = 0, out_invalid = 0, flag_sticky = 0. Data registers need not be reset.
- Reset is asynchronous. Beats in flight at assertion are discarded; nothing is emitted after release.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A beat is delivered when out_valid && out_ready.
  - in_ready = !stage_valid[last] || out_ready, combinational from out_ready.
  - Each stage advances when its successor is empty or advancing, so bubbles collapse.
  - Payload must be stable while out_valid && !out_ready.
  - Throughput is 1 beat/cycle with out_ready held high.
  - Latency is STAGES cycles from accept to out_valid.
- Stage 1 (registered):
  - Decode zero/normal/inf/NaN flags for X and Y.
  - Compute the magnitude compare of {exp,frac} as two half-width unsigned compares, high and low.
  - Register the flags, the partial compares, the signs and in_op.
- Final stage: merge the halves, then form lt, eq and gt:
  - unord = nanX | nanY.
  - Zeros: +0 == -0.
  - Zero vs nonzero is decided by the nonzero operand's sign.
  - Inf vs inf is equal when signs match.
  - Inf beats every normal and zero.
  - Normal vs normal, opposite signs: the negative operand is less.
  - Normal vs normal, same sign: the magnitude compare decides, inverted when both are negative.
  - When unord = 1, lt = eq = gt = 0.
- Predicates:
  - LT = lt; LE = lt|eq; EQ = eq; GT = gt; GE = gt|eq.
  - NE = !eq, which is 1 when unordered.
  - ORD = !unord; UNO = unord.
- STAGES = 1: both steps in one registered stage. STAGES = 3: an extra register after the half compares.
- Simultaneous accept and deliver in one cycle is legal and must not drop or duplicate beats.

Optional Feature:
- Macro: FCMP_SIGNALING_EN.
- With macro:
  - out_invalid = 1 when the op is LT/LE/GT/GE and unord = 1.
  - flag_sticky is set on every delivered beat with out_invalid = 1.
  - flag_sticky is cleared by flag_clr; a set on the same cycle as flag_clr wins.
- Without macro: out_invalid and flag_sticky are constant 0, flag_clr is unused, and no sticky register is built.

Decomposition:
- Package fcmp_pkg:
  - exc_t enum (EXC_ZERO, EXC_NORMAL, EXC_INF, EXC_NAN).
  - cmp_op_t enum of the eight opcodes.
  - Classification struct {zero, normal, inf, nan, sign}.
- Sub-module fcmp_classify: pure combinational decoder of one operand into the struct, instantiated twice.
- The pipeline handshake stays in the top module.

Test Plan (WE=5, WF=5):
- 1.0 = 0x09E0, 2.0 = 0x0A00, -1.0 = 0x0DE0, +0 = 0x0000, -0 = 0x0400, NaN = 0x1800, +inf = 0x1000, -inf = 0x1400.
- LT x=0x09E0, y=0x0A00 -> out_res=1, out_unord=0, out_valid exactly STAGES cycles after accept. GT on the same pair -> 0.
- Signs and zeros: LT x=0x0DE0, y=0x0000 -> 1; EQ x=0x0000, y=0x0400 -> 1; GE x=0x1400, y=0x1400 -> 1.
- NaN operand (x=0x1800, y=0x09E0), one beat per opcode:
  - ops 0..4 -> 0; NE -> 1; ORD -> 0; UNO -> 1; out_unord=1.
  - With FCMP_SIGNALING_EN: out_invalid=1 on ops 0..4, flag_sticky=1 until flag_clr.
- Back-pressure: stream 8 random beats, hold out_ready=0 for 5 cycles mid-stream -> no loss or reorder; in_ready=0 while full; results match a scoreboard.
- Full throughput: in_valid=1, out_ready=1 for 100 beats -> 100 results in 100+STAGES cycles.
- Reset mid-stream: pulse rst_n low with 2 beats in flight -> out_valid=0 immediately (async); no stale result after release.

Source files
------------

// File: rtl/fcmp_pkg.sv
// Shared types and compare helpers for the pipelined FloPoCo comparator.
package fcmp_pkg;

  typedef enum logic [1:0] {
    EXC_ZERO   = 2'b00,
    EXC_NORMAL = 2'b01,
    EXC_INF    = 2'b10,
    EXC_NAN    = 2'b11
  } exc_t;

  typedef enum logic [2:0] {
    CMP_LT  = 3'd0,
    CMP_LE  = 3'd1,
    CMP_EQ  = 3'd2,
    CMP_GT  = 3'd3,
    CMP_GE  = 3'd4,
    CMP_NE  = 3'd5,
    CMP_ORD = 3'd6,
    CMP_UNO = 3'd7
  } cmp_op_t;

  typedef struct packed {
    logic zero;
    logic normal;
    logic inf;
    logic nan;
    logic sign;
  } cls_t;

  // First-stage payload: operand classes, half-width magnitude compares, opcode.
  typedef struct packed {
    cls_t    x;
    cls_t    y;
    logic    hi_lt;
    logic    hi_eq;
    logic    lo_lt;
    logic    lo_eq;
    cmp_op_t op;
  } s1_t;

  // Returns {lt, eq, gt}; all zero when either operand is NaN.
  function automatic logic [2:0] order3(input s1_t s);
    logic mag_lt, mag_eq, mag_gt;
    logic [2:0] r;
    mag_lt = s.hi_lt | (s.hi_eq & s.lo_lt);
    mag_eq = s.hi_eq & s.lo_eq;
    mag_gt = ~mag_lt & ~mag_eq;
    if (s.x.nan || s.y.nan) begin
      r = 3'b000;
    end else if (s.x.zero && s.y.zero) begin
      r = 3'b010;
    end else if (s.x.zero) begin
      r = s.y.sign ? 3'b001 : 3'b100;
    end else if (s.y.zero) begin
      r = s.x.sign ? 3'b100 : 3'b001;
    end else if (s.x.inf && s.y.inf) begin
      if (s.x.sign == s.y.sign) r = 3'b010;
      else                      r = s.x.sign ? 3'b100 : 3'b001;
    end else if (s.x.inf) begin
      r = s.x.sign ? 3'b100 : 3'b001;
    end else if (s.y.inf) begin
      r = s.y.sign ? 3'b001 : 3'b100;
    end else if (s.x.sign != s.y.sign) begin
      r = s.x.sign ? 3'b100 : 3'b001;
    end else if (mag_eq) begin
      r = 3'b010;
    end else if (s.x.sign) begin
      // Both negative: larger magnitude is the smaller value.
      r = {mag_gt, 1'b0, mag_lt};
    end else begin
      r = {mag_lt, 1'b0, mag_gt};
    end
    return r;
  endfunction

  function automatic logic eval_pred(input cmp_op_t op, input logic [2:0] ord,
                                     input logic unord);
    logic r;
    case (op)
      CMP_LT:  r = ord[2];
      CMP_LE:  r = ord[2] | ord[1];
      CMP_EQ:  r = ord[1];
      CMP_GT:  r = ord[0];
      CMP_GE:  r = ord[0] | ord[1];
      CMP_NE:  r = ~ord[1];
      CMP_ORD: r = ~unord;
      default: r = unord;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fcmp_classify.sv
// Combinational decoder of one FloPoCo operand into its class flags and sign.
module fcmp_classify
  import fcmp_pkg::*;
#(
  parameter int unsigned WE = 5,
  parameter int unsigned WF = 5
) (
  input  logic [WE+WF+2:0] opnd_i,
  output cls_t             cls_o
);

  exc_t             exc;
  logic [WE+WF-1:0] unused_mag;

  assign exc        = exc_t'(opnd_i[WE+WF+2:WE+WF+1]);
  assign unused_mag = opnd_i[WE+WF-1:0];

  // One-hot class decode from the exception field.
  always_comb begin
    cls_o      = '0;
    cls_o.sign = opnd_i[WE+WF];
    unique case (exc)
      EXC_ZERO:   cls_o.zero   = 1'b1;
      EXC_NORMAL: cls_o.normal = 1'b1;
      EXC_INF:    cls_o.inf    = 1'b1;
      EXC_NAN:    cls_o.nan    = 1'b1;
    endcase
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined FloPoCo floating-point comparator with valid/ready handshake.
// Optional FCMP_SIGNALING_EN adds the signalling-invalid output and sticky flag.
module fcmp_pipe
  import fcmp_pkg::*;
#(
  parameter int unsigned WE     = 5,
  parameter int unsigned WF     = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WE+WF+2:0] in_x,
  input  logic [WE+WF+2:0] in_y,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_res,
  output logic             out_unord,
  output logic             out_invalid,
  input  logic             flag_clr,
  output logic             flag_sticky
);

  localparam int unsigned MagW = WE + WF;
  localparam int unsigned LoW  = MagW / 2;
  localparam int unsigned Last = STAGES - 1;
  localparam int unsigned MidN = (STAGES > 1) ? STAGES - 1 : 1;

  cls_t              cls_x, cls_y;
  s1_t               s1_d, fin_src;
  logic [STAGES-1:0] vld_q, vld_d, rdy, ld;
  logic              acc;
  logic [2:0]        ord;
  logic              res_d, unord_d, res_q, unord_q;

  fcmp_classify #(.WE(WE), .WF(WF)) u_cls_x (.opnd_i(in_x), .cls_o(cls_x));
  fcmp_classify #(.WE(WE), .WF(WF)) u_cls_y (.opnd_i(in_y), .cls_o(cls_y));

  // Stage-1 payload: classes plus split high/low magnitude compares.
  always_comb begin
    s1_d       = '0;
    s1_d.x     = cls_x;
    s1_d.y     = cls_y;
    s1_d.hi_lt = in_x[MagW-1:LoW] < in_y[MagW-1:LoW];
    s1_d.hi_eq = in_x[MagW-1:LoW] == in_y[MagW-1:LoW];
    s1_d.lo_lt = in_x[LoW-1:0] < in_y[LoW-1:0];
    s1_d.lo_eq = in_x[LoW-1:0] == in_y[LoW-1:0];
    s1_d.op    = cmp_op_t'(in_op);
  end

  // A stage may load when it or any stage downstream of it has a free slot.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    rdy      = '0;
    for (int i = int'(Last); i >= 0; i--) begin
      all_full = all_full & vld_q[i];
      rdy[i]   = ~all_full | out_ready;
    end
  end

  assign in_ready = rdy[Last];
  assign acc      = in_valid & in_ready;

  // Next-state valid bits: each ready stage takes its predecessor's bit.
  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = rdy[0] ? acc : vld_q[0];
    for (int i = 1; i < int'(STAGES); i++) begin
      if (rdy[i]) vld_d[i] = vld_q[i-1];
    end
    ld = rdy & vld_d;
  end

  // Stage valid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  generate
    if (STAGES > 1) begin : g_mid
      s1_t mid_q [MidN];
      // Stage-1 payload and optional delay stage (data only, no reset).
      always_ff @(posedge clk) begin
        if (ld[0]) mid_q[0] <= s1_d;
        for (int i = 1; i < int'(MidN); i++) begin
          if (ld[i]) mid_q[i] <= mid_q[i-1];
        end
      end
      assign fin_src = mid_q[MidN-1];
    end else begin : g_flat
      assign fin_src = s1_d;
    end
  endgenerate

  // Final stage: merge halves, order, then apply the predicate.
  always_comb begin
    ord     = order3(fin_src);
    unord_d = fin_src.x.nan | fin_src.y.nan;
    res_d   = eval_pred(fin_src.op, ord, unord_d);
  end

  // Output result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= 1'b0;
      unord_q <= 1'b0;
    end else if (ld[Last]) begin
      res_q   <= res_d;
      unord_q <= unord_d;
    end
  end

  assign out_valid = vld_q[Last];
  assign out_res   = res_q;
  assign out_unord = unord_q;

`ifdef FCMP_SIGNALING_EN
  logic inv_d, inv_q, sticky_q;

  assign inv_d = unord_d & (fin_src.op inside {CMP_LT, CMP_LE, CMP_GT, CMP_GE});

  // Invalid flag travels with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        inv_q <= 1'b0;
    else if (ld[Last]) inv_q <= inv_d;
  end

  // Sticky invalid: a delivered invalid beat beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               sticky_q <= 1'b0;
    else if (out_valid && out_ready && inv_q) sticky_q <= 1'b1;
    else if (flag_clr)                        sticky_q <= 1'b0;
  end

  assign out_invalid = inv_q;
  assign flag_sticky = sticky_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign out_invalid     = 1'b0;
  assign flag_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed and scoreboarded checks for fcmp_pipe (WE=5, WF=5).
module tb_fcmp_pipe;

  localparam int STAGES = 2;
`ifdef FCMP_SIGNALING_EN
  localparam bit Sig = 1'b1;
`else
  localparam bit Sig = 1'b0;
`endif

  localparam logic [12:0] ONE  = 13'h09E0;
  localparam logic [12:0] TWO  = 13'h0A00;
  localparam logic [12:0] MONE = 13'h0DE0;
  localparam logic [12:0] MTWO = 13'h0E00;
  localparam logic [12:0] PZ   = 13'h0000;
  localparam logic [12:0] MZ   = 13'h0400;
  localparam logic [12:0] QNAN = 13'h1800;
  localparam logic [12:0] PINF = 13'h1000;
  localparam logic [12:0] MINF = 13'h1400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [12:0] in_x, in_y;
  logic [2:0]  in_op;
  logic        out_res, out_unord, out_invalid, flag_clr, flag_sticky;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [12:0] x;
    logic [12:0] y;
    logic [2:0]  op;
    logic        res;
    logic        unord;
    logic        inv;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fcmp_pipe #(.WE(5), .WF(5), .STAGES(STAGES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_unord   (out_unord),
    .out_invalid (out_invalid),
    .flag_clr    (flag_clr),
    .flag_sticky (flag_sticky)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic inv_exp(input logic [2:0] op, input logic unord);
    return Sig && unord && (op == 3'd0 || op == 3'd1 || op == 3'd3 || op == 3'd4);
  endfunction

  task automatic add(input logic [12:0] x, input logic [12:0] y, input logic [2:0] op,
                     input logic res, input logic unord);
    vec_t v;
    v.x = x; v.y = y; v.op = op; v.res = res; v.unord = unord;
    v.inv = inv_exp(op, unord);
    vecs.push_back(v);
  endtask

  // Reference value of an operand as a real; infinities as +-1e300.
  function automatic real val(input logic [12:0] v);
    real m;
    int  e;
    m = 1.0 + real'(int'(v[4:0])) / 32.0;
    e = int'(v[9:5]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    if (v[12:11] == 2'b00)      m = 0.0;
    else if (v[12:11] == 2'b10) m = 1.0e300;
    if (v[10]) m = -m;
    return m;
  endfunction

  // Returns {res, unord, inv}.
  function automatic logic [2:0] model(input logic [12:0] x, input logic [12:0] y,
                                       input logic [2:0] op);
    logic un, lt, eq, gt, r;
    real  a, b;
    un = (x[12:11] == 2'b11) || (y[12:11] == 2'b11);
    a  = val(x);
    b  = val(y);
    lt = !un && (a < b);
    eq = !un && (a == b);
    gt = !un && (a > b);
    case (op)
      3'd0:    r = lt;
      3'd1:    r = lt | eq;
      3'd2:    r = eq;
      3'd3:    r = gt;
      3'd4:    r = gt | eq;
      3'd5:    r = !eq;
      3'd6:    r = !un;
      default: r = un;
    endcase
    return {r, un, inv_exp(op, un)};
  endfunction

  function automatic logic [12:0] rnd_opnd();
    logic [12:0] v;
    case ($urandom_range(0, 9))
      0:       v = PZ;
      1:       v = MZ;
      2:       v = PINF;
      3:       v = MINF;
      4:       v = QNAN;
      default: v = {2'b01, 1'($urandom_range(0, 1)), 5'($urandom_range(14, 16)),
                    5'($urandom_range(0, 3))};
    endcase
    return v;
  endfunction

  // Single beat into an empty pipe; checks latency and payload.
  task automatic run_one(input vec_t v, input int idx);
    bit seen;
    @(negedge clk);
    in_x = v.x; in_y = v.y; in_op = v.op; in_valid = 1'b1; out_ready = 1'b1;
    #1 check($sformatf("vec%0d in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= STAGES + 3 && !seen; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (out_valid) begin
        seen = 1;
        check($sformatf("vec%0d latency", idx), k, STAGES);
        check($sformatf("vec%0d res/unord/inv", idx), {out_res, out_unord, out_invalid},
              {v.res, v.unord, v.inv});
      end
    end
    if (!seen) check($sformatf("vec%0d out_valid timeout", idx), 0, 1);
  endtask

  // Streams random beats against the scoreboard, stalling out_ready in [stall_lo, stall_hi).
  task automatic stream(input int nbeats, input int stall_lo, input int stall_hi,
                        output int ncyc);
    logic [2:0]  sb[$];
    logic [2:0]  exp;
    logic [12:0] bx, by;
    logic [2:0]  bop;
    int          sent, got, cyc;
    bit          have;
    sent = 0; got = 0; cyc = 0; have = 0;
    bx = '0; by = '0; bop = '0;
    while (got < nbeats && cyc < nbeats * 4 + 50) begin
      @(negedge clk);
      if (!have && sent < nbeats) begin
        bx = rnd_opnd(); by = rnd_opnd(); bop = 3'($urandom_range(0, 7)); have = 1;
      end
      in_valid  = have;
      in_x      = bx; in_y = by; in_op = bop;
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      #1;
      if (stall_hi > stall_lo && cyc == stall_lo + 3) begin
        check("stall out_valid held", out_valid, 1);
        check("stall in_ready low", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stream spurious result", 1, 0);
        end else begin
          exp = sb.pop_front();
          check($sformatf("stream beat %0d", got), {out_res, out_unord, out_invalid}, exp);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(bx, by, bop));
        have = 0;
        sent++;
      end
      cyc++;
    end
    ncyc = cyc;
    check("stream beats delivered", got, nbeats);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int nc;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_op = '0;
    out_ready = 1'b1; flag_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_res", out_res, 0);
    check("reset out_unord", out_unord, 0);
    check("reset out_invalid", out_invalid, 0);
    check("reset flag_sticky", flag_sticky, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;

    add(ONE,  TWO,  3'd0, 1'b1, 1'b0);
    add(ONE,  TWO,  3'd3, 1'b0, 1'b0);
    add(MONE, PZ,   3'd0, 1'b1, 1'b0);
    add(PZ,   MZ,   3'd2, 1'b1, 1'b0);
    add(MINF, MINF, 3'd4, 1'b1, 1'b0);
    add(TWO,  ONE,  3'd1, 1'b0, 1'b0);
    add(ONE,  ONE,  3'd5, 1'b0, 1'b0);
    add(PINF, TWO,  3'd3, 1'b1, 1'b0);
    add(MONE, ONE,  3'd0, 1'b1, 1'b0);
    add(MONE, MTWO, 3'd3, 1'b1, 1'b0);
    add(PINF, MINF, 3'd2, 1'b0, 1'b0);
    add(MZ,   MONE, 3'd3, 1'b1, 1'b0);
    add(ONE,  TWO,  3'd6, 1'b1, 1'b0);
    add(ONE,  QNAN, 3'd3, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd0, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd1, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd2, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd3, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd4, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd5, 1'b1, 1'b1);
    add(QNAN, ONE,  3'd6, 1'b0, 1'b1);
    add(QNAN, ONE,  3'd7, 1'b1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) run_one(vecs[i], i);

    // Sticky invalid holds until cleared.
    @(negedge clk);
    #1 check("sticky after NaN compares", flag_sticky, Sig);
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    #1 check("sticky after clear", flag_sticky, 0);

    stream(8, 3, 8, nc);
    stream(100, 0, 0, nc);
    check("throughput cycles", nc, 100 + STAGES);

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_x = ONE; in_y = TWO; in_op = 3'd0;
    @(negedge clk);
    in_x = TWO; in_y = ONE;
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("async reset out_valid", out_valid, 0);
    check("async reset out_res", out_res, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check($sformatf("post-reset no stale %0d", k), out_valid, 0);
    end
    check("post-reset in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
